time_uart_formatter: RTL and testbench

TIME_UART_FORMATTER -- requirements
Module: time_uart_formatter

---
 rtl/time_uart_formatter_if.sv | 34 +++
 rtl/time_uart_formatter.sv | 174 +++++++++++++++++
 tb/tb_time_uart_formatter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/time_uart_formatter_if.sv
// Handshake bundle between a time-of-day source, the frame formatter and a UART transmitter.
// The formatter connects through the slave modport. The bench or system side uses the master modport.
interface time_uart_formatter_if;
  logic       send;
  logic [5:0] minutes;
  logic [5:0] hours;
  logic       txDone;
  logic       startTransmission;
  logic [7:0] dataBits;
  logic       busy;
  logic       error;

  modport master (
    output send,
    output minutes,
    output hours,
    output txDone,
    input  startTransmission,
    input  dataBits,
    input  busy,
    input  error
  );

  modport slave (
    input  send,
    input  minutes,
    input  hours,
    input  txDone,
    output startTransmission,
    output dataBits,
    output busy,
    output error
  );
endinterface

// File: rtl/time_uart_formatter.sv
// Sends a snapshot of the current time as "HH:MM" CR LF, one character per UART handshake.
// A handshake that is never acknowledged aborts the frame and sets a sticky error flag.
module time_uart_formatter #(
  parameter int NrOfChars  = 7,
  parameter int AckTimeout = 1024
) (
  input logic                  clock,
  input logic                  reset,
  time_uart_formatter_if.slave bus
);

  localparam int            CntW    = $clog2(AckTimeout + 1);
  localparam logic [2:0]    LastIdx = 3'(NrOfChars - 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(AckTimeout - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE,
    NEXT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      idx;
  logic [5:0]      hours_q;
  logic [5:0]      minutes_q;
  logic [7:0]      data_q;
  logic            error_q;
  logic [CntW-1:0] tmo_cnt;

  logic snap_en;
  logic load_en;
  logic idx_clr;
  logic idx_inc;
  logic cnt_clr;
  logic cnt_inc;
  logic err_set;

  function automatic logic [7:0] ascii_tens(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return 8'h30 + {2'b00, t};
  endfunction

  function automatic logic [7:0] ascii_ones(input logic [5:0] v);
    logic [5:0] o;
    o = v % 6'd10;
    return 8'h30 + {2'b00, o};
  endfunction

  function automatic logic [7:0] frame_char(input logic [2:0] i,
                                            input logic [5:0] h,
                                            input logic [5:0] m);
    logic [7:0] c;
    case (i)
      3'd0:    c = ascii_tens(h);
      3'd1:    c = ascii_ones(h);
      3'd2:    c = 8'h3A;
      3'd3:    c = ascii_tens(m);
      3'd4:    c = ascii_ones(m);
      3'd5:    c = 8'h0D;
      3'd6:    c = 8'h0A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    snap_en   = 1'b0;
    load_en   = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        // A request while the transmitter is still busy is dropped, not queued.
        if (bus.send && bus.txDone) begin
          snap_en   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_en   = 1'b1;
        state_nxt = START;
      end
      START: begin
        cnt_clr   = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!bus.txDone) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_cnt == TmoLast) begin
          err_set   = 1'b1;
          idx_clr   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.txDone) begin
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (idx == LastIdx) begin
          idx_clr   = 1'b1;
          state_nxt = IDLE;
        end else begin
          idx_inc   = 1'b1;
          state_nxt = LOAD;
        end
      end
      default: begin
        idx_clr   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx       <= 3'd0;
      hours_q   <= 6'd0;
      minutes_q <= 6'd0;
      data_q    <= 8'h00;
      error_q   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      if (snap_en) begin
        hours_q   <= bus.hours;
        minutes_q <= bus.minutes;
      end
      if (idx_clr) begin
        idx <= 3'd0;
      end else if (idx_inc) begin
        idx <= idx + 3'd1;
      end
      // The character is held until the next LOAD, so it stays stable for the whole handshake.
      if (load_en) begin
        data_q <= frame_char(idx, hours_q, minutes_q);
      end
      if (cnt_clr) begin
        tmo_cnt <= '0;
      end else if (cnt_inc) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (err_set) begin
        error_q <= 1'b1;
      end
    end
  end

  assign bus.startTransmission = (state == START);
  assign bus.busy              = (state != IDLE);
  assign bus.dataBits          = data_q;
  assign bus.error             = error_q;

endmodule

// File: tb/tb_time_uart_formatter.sv
// Bench for time_uart_formatter: a vector table of frames, a simple UART model, and a character scoreboard.
// Hand-written sequences cover snapshotting, handshake timeout, reset mid-frame and a held request.
module tb_time_uart_formatter;

  logic clock;
  logic reset;
  time_uart_formatter_if bus ();

  time_uart_formatter #(
    .NrOfChars (7),
    .AckTimeout(1024)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;
  int pulses = 0;
  logic [7:0] exp_q[$];

  // UART model: txDone drops 3 cycles after a start pulse and stays low for 20 cycles.
  int uart_cnt      = 0;
  bit uart_dead     = 1'b0;
  bit uart_hold_low = 1'b0;

  always @(posedge clock) begin
    if (uart_cnt != 0) begin
      uart_cnt <= (uart_cnt == 23) ? 0 : uart_cnt + 1;
    end else if (bus.startTransmission && !uart_dead) begin
      uart_cnt <= 1;
    end
  end

  assign bus.txDone = !uart_hold_low && !(uart_cnt >= 3 && uart_cnt < 23);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  bit prev_start = 1'b0;

  always @(negedge clock) begin
    if (bus.startTransmission) begin
      pulses++;
      check("single_pulse", 32'(prev_start), 32'd0);
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_pulse: got char %0h, expected no pulse", bus.dataBits);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        tests--;
        check("char", 32'(bus.dataBits), 32'(e));
      end
    end
    prev_start = bus.startTransmission;
  end

  // Held-request mode: each new frame seen on busy pushes its expected characters.
  bit          held_mode   = 1'b0;
  int          frames_seen = 0;
  bit          prev_busy   = 1'b0;
  logic [55:0] held_exp    = 56'h30373A34320D0A;

  task automatic push_frame(input logic [55:0] e);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(e[55-8*i -: 8]);
    end
  endtask

  always @(negedge clock) begin
    if (held_mode && bus.busy && !prev_busy) begin
      frames_seen++;
      push_frame(held_exp);
    end
    prev_busy = bus.busy;
  end

  task automatic send_pulse(input logic [5:0] h, input logic [5:0] m);
    @(negedge clock);
    bus.hours   = h;
    bus.minutes = m;
    bus.send    = 1'b1;
    @(negedge clock);
    bus.send    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus.busy || !bus.txDone) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      failed++;
      $display("FAIL %s: got busy after %0d cycles, expected idle", name, n);
    end
  endtask

  typedef struct packed {
    logic [5:0]  h;
    logic [5:0]  m;
    logic [55:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int p0;
    int n;

    vecs[0] = '{6'd12, 6'd34, 56'h31323A33340D0A};
    vecs[1] = '{6'd0,  6'd59, 56'h30303A35390D0A};
    vecs[2] = '{6'd23, 6'd0,  56'h32333A30300D0A};
    vecs[3] = '{6'd9,  6'd5,  56'h30393A30350D0A};
    vecs[4] = '{6'd0,  6'd0,  56'h30303A30300D0A};
    vecs[5] = '{6'd63, 6'd63, 56'h36333A36330D0A};

    reset       = 1'b1;
    bus.send    = 1'b0;
    bus.hours   = 6'd0;
    bus.minutes = 6'd0;
    repeat (3) @(negedge clock);
    check("reset_busy",  32'(bus.busy), 32'd0);
    check("reset_start", 32'(bus.startTransmission), 32'd0);
    check("reset_data",  32'(bus.dataBits), 32'd0);
    check("reset_error", 32'(bus.error), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      p0 = pulses;
      push_frame(vecs[i].exp);
      send_pulse(vecs[i].h, vecs[i].m);
      wait_idle("frame_end");
      check("frame_pulses", 32'(pulses - p0), 32'd7);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Inputs changed mid-frame must not reach the frame.
    p0 = pulses;
    push_frame(56'h31323A33340D0A);
    send_pulse(6'd12, 6'd34);
    n = 0;
    while (pulses - p0 < 2 && n < 500) begin
      @(negedge clock);
      n++;
    end
    bus.minutes = 6'd35;
    bus.hours   = 6'd1;
    wait_idle("snapshot_end");
    check("snapshot_pulses", 32'(pulses - p0), 32'd7);
    check("snapshot_queue", 32'(exp_q.size()), 32'd0);

    // A request while txDone is low is dropped.
    uart_hold_low = 1'b1;
    p0 = pulses;
    send_pulse(6'd1, 6'd1);
    repeat (10) @(negedge clock);
    check("ignored_busy", 32'(bus.busy), 32'd0);
    check("ignored_pulses", 32'(pulses - p0), 32'd0);
    uart_hold_low = 1'b0;
    repeat (2) @(negedge clock);

    // Transmitter never acknowledges: one pulse, then timeout.
    uart_dead = 1'b1;
    p0 = pulses;
    exp_q.push_back(8'h31);
    send_pulse(6'd12, 6'd34);
    n = 0;
    while (pulses == p0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (!bus.error && n < 1200) begin
      @(negedge clock);
      n++;
    end
    check("timeout_window", 32'(n >= 1020 && n <= 1030), 32'd1);
    check("timeout_error", 32'(bus.error), 32'd1);
    check("timeout_busy", 32'(bus.busy), 32'd0);
    check("timeout_pulses", 32'(pulses - p0), 32'd1);
    uart_dead = 1'b0;
    repeat (3) @(negedge clock);

    p0 = pulses;
    push_frame(56'h32333A30300D0A);
    send_pulse(6'd23, 6'd0);
    wait_idle("after_timeout_end");
    check("after_timeout_pulses", 32'(pulses - p0), 32'd7);
    check("error_sticky", 32'(bus.error), 32'd1);
    check("after_timeout_queue", 32'(exp_q.size()), 32'd0);

    // Reset during the fourth character's WAIT_DONE.
    p0 = pulses;
    push_frame(56'h31323A33340D0A);
    send_pulse(6'd12, 6'd34);
    n = 0;
    while (pulses - p0 < 4 && n < 500) begin
      @(negedge clock);
      n++;
    end
    repeat (8) @(negedge clock);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_busy",  32'(bus.busy), 32'd0);
    check("midreset_start", 32'(bus.startTransmission), 32'd0);
    check("midreset_data",  32'(bus.dataBits), 32'd0);
    check("midreset_error", 32'(bus.error), 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    p0 = pulses;
    repeat (60) @(negedge clock);
    check("post_reset_pulses", 32'(pulses - p0), 32'd0);
    check("post_reset_busy", 32'(bus.busy), 32'd0);
    wait_idle("post_reset_idle");

    // Held request: three back-to-back frames separated by idle cycles.
    p0 = pulses;
    frames_seen = 0;
    held_mode = 1'b1;
    @(negedge clock);
    bus.hours   = 6'd7;
    bus.minutes = 6'd42;
    bus.send    = 1'b1;
    n = 0;
    while (frames_seen < 3 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    bus.send = 1'b0;
    wait_idle("held_end");
    held_mode = 1'b0;
    check("held_frames", 32'(frames_seen), 32'd3);
    check("held_pulses", 32'(pulses - p0), 32'd21);
    check("held_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
